// File: rtl/tone_pkg.sv
// Shared types and elaboration-time helpers for the keypad tone generator:
// FSM states, note frequencies, half-period math and keypad code decoding.
package tone_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, REST, GAP} state_t;

   localparam int FREQ_A = 440;
   localparam int FREQ_B = 494;
   localparam int FREQ_C = 523;
   localparam int FREQ_D = 587;
   localparam int FREQ_E = 659;
   localparam int FREQ_F = 698;
   localparam int FREQ_G = 784;

   localparam logic [2:0] NOTE_REST = 3'd7;

   // Divider half-period in clk cycles; never below 1 so the divider always toggles.
   function automatic int half_period(input int clk_hz, input int freq);
      int hp;
      hp = clk_hz / (2 * freq);
      return (hp < 1) ? 1 : hp;
   endfunction

   function automatic logic [2:0] code_to_note(input logic [3:0] code);
      logic [2:0] idx;
      case (code)
         4'hA:    idx = 3'd0;
         4'hB:    idx = 3'd1;
         4'hC:    idx = 3'd2;
         4'hD:    idx = 3'd3;
         4'hE:    idx = 3'd4;
         4'hF:    idx = 3'd5;
         4'h0:    idx = 3'd6;
         default: idx = NOTE_REST;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: toggles tone every hp cycles while enabled.
// restart or a disabled divider clears both the count and the tone.
module tone_divider #(
   parameter int DIV_WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 restart,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] hp,
   output logic                 tone
);

   logic [DIV_WIDTH-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tone    <= 1'b0;
      end else if (restart || !enable) begin
         div_cnt <= '0;
         tone    <= 1'b0;
      end else if (div_cnt == hp - DIV_WIDTH'(1)) begin
         div_cnt <= '0;
         tone    <= ~tone;
      end else begin
         div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/keypad_tone_generator.sv
// Keypad-to-speaker tone generator: a key press plays a note (or a rest) for
// NOTE_TICKS cycles followed by a GAP_TICKS silent gap; new keys preempt.
module keypad_tone_generator
   import tone_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int SPK_WIDTH  = 8,
   parameter int DIV_WIDTH  = 20,
   parameter int DUR_WIDTH  = 27,
   parameter int NOTE_TICKS = 50_000_000,
   parameter int GAP_TICKS  = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           key_code,
   input  logic                 key_valid,
   input  logic                 mute,
   output logic [SPK_WIDTH-1:0] spk,
   output logic                 busy,
   output logic [2:0]           note_idx
);

   localparam logic [DIV_WIDTH-1:0] HP_A = DIV_WIDTH'(half_period(CLK_HZ, FREQ_A));
   localparam logic [DIV_WIDTH-1:0] HP_B = DIV_WIDTH'(half_period(CLK_HZ, FREQ_B));
   localparam logic [DIV_WIDTH-1:0] HP_C = DIV_WIDTH'(half_period(CLK_HZ, FREQ_C));
   localparam logic [DIV_WIDTH-1:0] HP_D = DIV_WIDTH'(half_period(CLK_HZ, FREQ_D));
   localparam logic [DIV_WIDTH-1:0] HP_E = DIV_WIDTH'(half_period(CLK_HZ, FREQ_E));
   localparam logic [DIV_WIDTH-1:0] HP_F = DIV_WIDTH'(half_period(CLK_HZ, FREQ_F));
   localparam logic [DIV_WIDTH-1:0] HP_G = DIV_WIDTH'(half_period(CLK_HZ, FREQ_G));

   localparam logic [DUR_WIDTH-1:0] NOTE_LAST = DUR_WIDTH'(NOTE_TICKS - 1);
   localparam logic [DUR_WIDTH-1:0] GAP_LAST  = DUR_WIDTH'(GAP_TICKS - 1);

   state_t               state;
   logic [DUR_WIDTH-1:0] dur_cnt;
   logic [DIV_WIDTH-1:0] hp;
   logic [2:0]           new_note;
   logic [DIV_WIDTH-1:0] new_hp;
   logic                 note_end;
   logic                 tone;

   always_comb begin
      new_note = code_to_note(key_code);
      case (new_note)
         3'd0:    new_hp = HP_A;
         3'd1:    new_hp = HP_B;
         3'd2:    new_hp = HP_C;
         3'd3:    new_hp = HP_D;
         3'd4:    new_hp = HP_E;
         3'd5:    new_hp = HP_F;
         3'd6:    new_hp = HP_G;
         default: new_hp = HP_A;
      endcase
   end

   assign note_end = ((state == PLAY) || (state == REST)) && (dur_cnt == NOTE_LAST);
   assign busy     = (state != IDLE);

   // A new key always wins, even on the cycle a note or gap would end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         dur_cnt  <= '0;
         hp       <= '0;
         note_idx <= NOTE_REST;
      end else if (key_valid) begin
         state    <= (new_note == NOTE_REST) ? REST : PLAY;
         dur_cnt  <= '0;
         hp       <= new_hp;
         note_idx <= new_note;
      end else begin
         case (state)
            PLAY, REST: begin
               if (note_end) begin
                  state   <= GAP;
                  dur_cnt <= '0;
               end else begin
                  dur_cnt <= dur_cnt + DUR_WIDTH'(1);
               end
            end
            GAP: begin
               if (dur_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  dur_cnt <= '0;
               end else begin
                  dur_cnt <= dur_cnt + DUR_WIDTH'(1);
               end
            end
            default: dur_cnt <= '0;
         endcase
      end
   end

   tone_divider #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(key_valid | note_end),
      .enable (state == PLAY),
      .hp     (hp),
      .tone   (tone)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spk <= '0;
      else        spk <= {SPK_WIDTH{tone & ~mute}};
   end

endmodule

// File: doc/keypad_tone_generator.md
# keypad_tone_generator

Parametrised keypad-to-speaker tone generator. It accepts a 4-bit keypad code with a valid strobe and maps the code to a musical note (A–G) or a rest. It plays that note as a square wave for a fixed duration, followed by a short silent gap. It sits between the keypad decoder and the speaker pins, and replaces the external per-note clock inputs with an internal programmable divider.

## Interface
Parameters:
- CLK_HZ, 100_000_000, frequency of clk in Hz; all note half-periods derive from it.
- SPK_WIDTH, 8, number of speaker output bits; every bit carries the same tone.
- DIV_WIDTH, 20, width of the half-period divider counter; must hold CLK_HZ/(2*262).
- DUR_WIDTH, 27, width of the duration counter.
- NOTE_TICKS, 50_000_000, clk cycles a note or rest sounds; must be ≥ 1.
- GAP_TICKS, 5_000_000, silent clk cycles after each note; must be ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_code  in  4  keypad code; sampled only when key_valid=1.
- key_valid  in  1  one-cycle strobe: key_code holds a new key press.
- mute  in  1  forces spk low; the state machine keeps running.
- spk  out  SPK_WIDTH  speaker drive, registered; all bits identical.
- busy  out  1  high whenever the state is not IDLE.
- note_idx  out  3  latched note index (0=A … 6=G, 7=rest).

## Operation
- Code map:
  - 0xA→A 440 Hz, 0xB→B 494 Hz, 0xC→C 523 Hz, 0xD→D 587 Hz, 0xE→E 659 Hz, 0xF→F 698 Hz, 0x0→G 784 Hz.
  - 0x1–0x9 → rest (note_idx=7).
- Half-period HP = floor(CLK_HZ/(2*freq)), clamped to a minimum of 1. It is computed at elaboration, never at run time.
- States:
  - IDLE: spk=0, tone=0.
  - PLAY: divider running.
  - REST: tone held at 0, duration counting.
  - GAP: tone=0, gap counting.
- IDLE + key_valid → PLAY (note) or REST (rest code). On entry: note_idx and HP latched, div_cnt=0, dur_cnt=0, tone=0.
- PLAY: div_cnt increments each cycle. When div_cnt==HP-1, tone toggles and div_cnt returns to 0.
- PLAY and REST: dur_cnt increments each cycle. At dur_cnt==NOTE_TICKS-1 the next state is GAP, with dur_cnt=0 and tone=0.
- GAP: at dur_cnt==GAP_TICKS-1 the next state is IDLE.
- Preemption:
  - key_valid in PLAY, REST or GAP restarts immediately with the new code, using the same entry actions as from IDLE.
  - If key_valid coincides with the terminal count, the new key wins.
- spk is registered each cycle as {SPK_WIDTH{tone & ~mute}}.
- busy = (state != IDLE).
- Counters never wrap past their terminal counts.

## Timing
- Reset (async assert, sync release) → state=IDLE, spk=0, busy=0, note_idx=7, all counters 0.
- key_valid sampled at edge N:
  - busy=1 and note_idx are valid after edge N.
  - The first tone rise is registered into spk at edge N+HP+1.
- Tone period is 2*HP cycles with 50% duty.
- Note duration is exactly NOTE_TICKS cycles from entry to GAP. The gap is exactly GAP_TICKS cycles. busy falls NOTE_TICKS+GAP_TICKS cycles after entry.
- mute takes effect on spk one cycle after it changes.
- Reset asserted mid-note silences spk immediately; no note resumes after release.

## Structure
- tone_pkg holds:
  - a state enum {IDLE, PLAY, REST, GAP};
  - the note frequency constants;
  - function half_period(clk_hz, freq);
  - function code_to_note(code) → 3-bit index.
- Sub-module tone_divider is the natural split. It has inputs clk, rst_n, restart, enable and hp[DIV_WIDTH-1:0], and output tone. It owns div_cnt and the toggle logic.
- The top level owns the FSM, the duration counter, the latches and the output register.

## Test plan
Bench parameters: CLK_HZ=88_000, NOTE_TICKS=1000, GAP_TICKS=50, SPK_WIDTH=8.
- Reset check: hold rst_n=0, then release → spk=0x00, busy=0, note_idx=7. With no key pressed, spk stays 0 for 2000 cycles.
- Note A: key_valid with code 0xA → HP=100; first spk=0xFF at +101 cycles; period 200 cycles; GAP after 1000 cycles; busy low after 1050.
- Notes G and C: code 0x0 → period 112 cycles. Code 0xC → period 168 cycles. Check that note_idx reads 6 and 2 respectively.
- Rest: code 0x5 → busy=1 and spk=0 for 1050 cycles, note_idx=7.
- Preemption: 0xA, then 0xE at cycle 500 → divider restarts with HP=66 (period 132); GAP occurs 1000 cycles after the 0xE strobe.
- Mute and mid-note reset:
  - mute=1 for cycles 300–400 of note B → spk=0 over that window; the tone phase continues afterward, period 178 (HP=89).
  - rst_n low mid-note → spk=0 immediately; stays idle after release.
